mem_bus_arbiter: RTL

Shares the single unified instruction/data memory port between two requesters:
- m0: multi-cycle MIPS core fetch/load/store path.
- m1: program loader / DMA engine.

Round-robin arbitration gives one access per grant. m1 may hold bounded burst priority through a lock. Read data is returned with a fixed latency to the owning requester. Sits between the core's memory-address mux and the memory/GPIO decode.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rd_tag_pipe.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter: read-return owner tags,
// arbitration states and the lock counter sizing helper.
package mem_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_M0   = 2'd1;
    localparam owner_t OWN_M1   = 2'd2;

    typedef enum logic {
        ST_RR   = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Counter must be able to hold the value MAX_LOCK itself.
    function automatic int lock_cnt_width(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Owner-tag delay line matching the memory read latency; the exiting tag tells
// the arbiter which requester the current mem_rdata belongs to.
import mem_arb_pkg::*;

module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] push_tag,
    output logic [1:0] exit_tag
);

    owner_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign exit_tag = stage[DEPTH-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the unified memory port between the core (m0)
// and the loader/DMA (m1), with bounded m1 burst lock and tagged read return.
import mem_arb_pkg::*;

module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_LOCK   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_stall
);

    localparam int LCW = lock_cnt_width(MAX_LOCK);
    localparam logic [LCW-1:0] LOCK_LIMIT = LCW'(MAX_LOCK);

    arb_state_t            state, state_next;
    logic [LCW-1:0]        lock_cnt, lock_cnt_next;
    owner_t                last_owner, last_owner_next;
    logic                  rr_m0, rr_m1;
    logic                  grant_m0, grant_m1;
    owner_t                push_tag, exit_tag;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

    // State register; last_owner starts at m1 so the core wins the first conflict.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_RR;
            lock_cnt   <= '0;
            last_owner <= OWN_M1;
        end else begin
            state      <= state_next;
            lock_cnt   <= lock_cnt_next;
            last_owner <= last_owner_next;
        end
    end

    assign rr_m0 = m0_req & (~m1_req | (last_owner != OWN_M0));
    assign rr_m1 = m1_req & ~rr_m0;

    // Next-state and grant decision; the locking grant already counts toward MAX_LOCK.
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        grant_m0      = 1'b0;
        grant_m1      = 1'b0;
        if (reset) begin
            case (state)
                ST_RR: begin
                    grant_m0      = rr_m0;
                    grant_m1      = rr_m1;
                    lock_cnt_next = '0;
                    if (rr_m1 && m1_lock) begin
                        state_next    = ST_LOCK;
                        lock_cnt_next = m0_req ? LCW'(1) : '0;
                    end
                end
                ST_LOCK: begin
                    if (m1_req && m1_lock) begin
                        if (m0_req && (lock_cnt == LOCK_LIMIT)) begin
                            grant_m0      = 1'b1;
                            lock_cnt_next = '0;
                            state_next    = ST_RR;
                        end else begin
                            grant_m1 = 1'b1;
                            if (m0_req) begin
                                lock_cnt_next = lock_cnt + LCW'(1);
                            end
                        end
                    end else begin
                        grant_m0      = rr_m0;
                        grant_m1      = rr_m1;
                        lock_cnt_next = '0;
                        state_next    = ST_RR;
                    end
                end
                default: begin
                    lock_cnt_next = '0;
                    state_next    = ST_RR;
                end
            endcase
        end
        last_owner_next = grant_m0 ? OWN_M0 : (grant_m1 ? OWN_M1 : last_owner);
    end

    // Port outputs: memory mux, stall and read-tag generation.
    always_comb begin
        m0_gnt    = grant_m0;
        m1_gnt    = grant_m1;
        cpu_stall = m0_req & ~grant_m0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        push_tag  = OWN_NONE;
        if (grant_m0) begin
            mem_en    = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            push_tag  = m0_we ? OWN_NONE : OWN_M0;
        end else if (grant_m1) begin
            mem_en    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            push_tag  = m1_we ? OWN_NONE : OWN_M1;
        end
    end

    rd_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .push_tag (push_tag),
        .exit_tag (exit_tag)
    );

    // Read data passes straight through on its return cycle and is held afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (m0_rvalid) begin
                m0_rdata_q <= mem_rdata;
            end
            if (m1_rvalid) begin
                m1_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        m0_rvalid = reset & (exit_tag == OWN_M0);
        m1_rvalid = reset & (exit_tag == OWN_M1);
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (reset) begin
            m0_rdata = m0_rvalid ? mem_rdata : m0_rdata_q;
            m1_rdata = m1_rvalid ? mem_rdata : m1_rdata_q;
        end
    end

endmodule
